dram_cim_chip_emu: RTL and testbench
====================================

// Module: dram_cim_chip_emu
// PURPOSE
// - Chip-side emulator of the 16-core CIM DRAM pin protocol: the far end of the FPGA-side controller/init pins.
// - Deserialises ADDIN/RAD/DIN, commits rows on WRIEN, and streams rows back on ROUT on RDEN.
// - Used for FPGA loopback and for closed-loop simulation of AES key/SBOX init plus AES reads, with no silicon attached.
// PARAMETERS
// NCORE  16  number of DRAM cores (one RAD/DIN/LIMIN/ROUT lane each)
// ROW_AW 6   row address width; rows per core = 2**ROW_AW
// ROW_W  64  bits per row
// PORTS
// CLK      in  1      system clock; all logic on its rising edge; must be >= 4x CLK_chip
// RST      in  1      asynchronous, active-high reset
// CLK_chip in  1      chip clock from FPGA pins; sampled as data, never used as a clock
// ADDIN    in  1      serial write-row address, MSB first
// ADVLD    in  1      address-shift enable (ADDIN and all RAD lanes)
// RAD      in  NCORE  serial per-core read-row address, MSB first
// DIN      in  NCORE  serial per-core write data, MSB first
// DVLD     in  1      data-shift enable
// WRIEN    in  1      write enable; a rising level commits the row
// RDEN     in  1      read enable; a rising level loads the row, then the row streams out
// LIMSEL   in  2      logic-in-memory op select (used only with DRAM_EMU_LIM_EN)
// LIMIN    in  NCORE  logic-in-memory operand lane per core (used only with DRAM_EMU_LIM_EN)
// ROUT     out NCORE  serial read data per core, MSB first
// BUSY     out 1      high in WR or RD state
// ERR      out 1      sticky protocol-violation flag
// BEHAVIOUR
// - Input sync: every pin input passes through a 2-flop synchroniser on CLK.
// - chip_rise = synced CLK_chip 0->1. It is a 1-CLK pulse, 3 CLK after the pin edge.
// - All control/data pins are evaluated only on chip_rise, using their synced values, so they stay aligned.
// - Reset: ROUT=0, BUSY=0, ERR=0, all shift regs=0, state=IDLE. Memory array is NOT reset.
// - Reset mid-operation aborts any read stream or pending commit. Memory keeps its last committed contents.
// - On chip_rise with ADVLD=1: waddr_sr <= {waddr_sr[ROW_AW-2:0],ADDIN}; per core i, raddr_sr[i] shifts in RAD[i].
// - On chip_rise with DVLD=1: per core i, wdata_sr[i] <= {wdata_sr[i][ROW_W-2:0],DIN[i]}.
// - Shift regs keep only the last ROW_AW / ROW_W bits shifted in (overflow discards the oldest bits).
// - ADVLD and DVLD are independent; both may shift on the same chip_rise.
// - FSM (evaluated on chip_rise; wr_rise/rd_rise = WRIEN/RDEN 0->1 between consecutive chip_rises):
//   - IDLE: wr_rise & rd_rise -> set ERR, stay IDLE, no access. wr_rise -> WR. rd_rise -> RD.
//   - WR: on entry, mem[i][waddr_sr] <= wdata_sr[i] for all cores (exactly one write per rise). Hold until WRIEN=0 -> IDLE.
//   - RD: on entry, rd_sr[i] <= mem[i][raddr_sr[i]]; ROUT[i] = MSB on the next CLK.
//     - Each later chip_rise with RDEN=1: rd_sr shifts left with 0 fill. After ROW_W bits, ROUT=0.
//     - RDEN=0 -> IDLE, ROUT=0.
// - WRIEN rising while in RD, or RDEN rising while in WR: set ERR, ignore it, remain in the current state.
// - Address/data shifts also occur in WR/RD. A shift coincident with a commit/load applies after the commit/load, which uses pre-shift values.
// - ROUT is 0 whenever state != RD.
// - ERR clears only on RST.
// - Read latency: RDEN pin rise -> first bit on ROUT = 4 CLK after the next CLK_chip pin rise.
// CONFIGURATION
// - DRAM_EMU_LIM_EN defined: the RD-entry load becomes f(row, LIMIN replicated to ROW_W):
//   - LIMSEL=00: row
//   - LIMSEL=01: row ^ L
//   - LIMSEL=10: row & L
//   - LIMSEL=11: row | L
// - Not defined: LIMSEL/LIMIN are ignored and raw row data is read. Port list is unchanged.
// TESTING
// - Write/read core 0, row 5: 64'hDEADBEEF_01234567 -> ROUT[0] streams 64 bits MSB first, then 0.
// - Write row 63 on all 16 cores with distinct data, then read row 63 with RAD = 6'd63 on every lane -> each lane returns its own row.
// - Shift 8 address bits 8'hA5 then WRIEN -> write lands in row 6'h25.
// - WRIEN and RDEN rise on the same chip clock -> ERR=1, memory unchanged, ROUT=0.
// - Assert RST mid-stream after 10 bits -> ROUT=0, BUSY=0 immediately. Re-read returns the original row.
// - With DRAM_EMU_LIM_EN, LIMSEL=01, LIMIN[0]=1, row=64'h0 -> ROUT[0] streams 64 ones.

Source files
------------

// File: rtl/dram_cim_chip_emu.sv
// ============================================================================
// Module  : dram_cim_chip_emu
// Brief   : Chip-side emulator of the 16-core CIM DRAM serial pin protocol.
//           Deserialises ADDIN/RAD/DIN, commits rows on WRIEN, streams rows
//           back on ROUT on RDEN. All pins are synchronised to CLK and only
//           evaluated on a detected rising edge of the synced CLK_chip.
//           Optional macro DRAM_EMU_LIM_EN adds logic-in-memory on row load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_cim_chip_emu #(
  parameter int NCORE  = 16,
  parameter int ROW_AW = 6,
  parameter int ROW_W  = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_chip,
  input  logic             ADDIN,
  input  logic             ADVLD,
  input  logic [NCORE-1:0] RAD,
  input  logic [NCORE-1:0] DIN,
  input  logic             DVLD,
  input  logic             WRIEN,
  input  logic             RDEN,
  input  logic [1:0]       LIMSEL,
  input  logic [NCORE-1:0] LIMIN,
  output logic [NCORE-1:0] ROUT,
  output logic             BUSY,
  output logic             ERR
);

  localparam int SW    = 6 + 2 * NCORE;
  localparam int NROWS = 2 ** ROW_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  logic [SW-1:0]    sync1, sync2;
  logic             clk_s, addin_s, advld_s, dvld_s, wrien_s, rden_s;
  logic [NCORE-1:0] rad_s, din_s;
  logic             clk_d, wr_prev, rd_prev;
  logic             chip_rise, wr_rise, rd_rise;
  state_t           state, state_nx;
  logic             do_write, do_load, do_shift, set_err;
  logic [ROW_AW-1:0] waddr_sr;
  logic [NCORE-1:0] rd_msb;
  logic [NCORE-1:0] rout_r;
  logic             err_r;

  // Two-flop synchroniser for every pin input
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {CLK_chip, ADDIN, ADVLD, DVLD, WRIEN, RDEN, RAD, DIN};
      sync2 <= sync1;
    end
  end

  assign {clk_s, addin_s, advld_s, dvld_s, wrien_s, rden_s, rad_s, din_s} = sync2;

`ifdef DRAM_EMU_LIM_EN
  logic [1:0]       lsel1, lsel_s;
  logic [NCORE-1:0] lim1, lim_s;

  // Synchronise the logic-in-memory controls alongside the other pins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lsel1  <= '0;
      lsel_s <= '0;
      lim1   <= '0;
      lim_s  <= '0;
    end else begin
      lsel1  <= LIMSEL;
      lsel_s <= lsel1;
      lim1   <= LIMIN;
      lim_s  <= lim1;
    end
  end
`else
  logic unused_lim;
  assign unused_lim = ^{LIMSEL, LIMIN};
`endif

  assign chip_rise = clk_s & ~clk_d;
  assign wr_rise   = wrien_s & ~wr_prev;
  assign rd_rise   = rden_s & ~rd_prev;

  // Edge history: chip clock every CLK, enables sampled once per chip_rise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_d   <= 1'b0;
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
    end else begin
      clk_d <= clk_s;
      if (chip_rise) begin
        wr_prev <= wrien_s;
        rd_prev <= rden_s;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-chip_rise action strobes
  always_comb begin
    state_nx = state;
    do_write = 1'b0;
    do_load  = 1'b0;
    do_shift = 1'b0;
    set_err  = 1'b0;
    if (chip_rise) begin
      case (state)
        S_IDLE: begin
          if (wr_rise && rd_rise) begin
            set_err = 1'b1;
          end else if (wr_rise) begin
            state_nx = S_WR;
            do_write = 1'b1;
          end else if (rd_rise) begin
            state_nx = S_RD;
            do_load  = 1'b1;
          end
        end
        S_WR: begin
          if (rd_rise)  set_err  = 1'b1;
          if (!wrien_s) state_nx = S_IDLE;
        end
        S_RD: begin
          if (wr_rise) set_err = 1'b1;
          if (!rden_s) state_nx = S_IDLE;
          else         do_shift = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Shared write-address shift register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     waddr_sr <= '0;
    else if (chip_rise && advld_s) waddr_sr <= {waddr_sr[ROW_AW-2:0], addin_s};
  end

  generate
    for (genvar i = 0; i < NCORE; i++) begin : g_core
      logic [ROW_W-1:0]  mem [NROWS];
      logic [ROW_AW-1:0] raddr_sr;
      logic [ROW_W-1:0]  wdata_sr;
      logic [ROW_W-1:0]  rd_sr;
      logic [ROW_W-1:0]  row;
      logic [ROW_W-1:0]  load_val;

      assign row = mem[raddr_sr];

`ifdef DRAM_EMU_LIM_EN
      logic [ROW_W-1:0] lane;
      assign lane = {ROW_W{lim_s[i]}};
      // Logic-in-memory transform applied on the row load
      always_comb begin
        load_val = row;
        case (lsel_s)
          2'b01:   load_val = row ^ lane;
          2'b10:   load_val = row & lane;
          2'b11:   load_val = row | lane;
          default: load_val = row;
        endcase
      end
`else
      assign load_val = row;
`endif

      // Per-core address and data deserialisers (commit/load sees pre-shift values)
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          raddr_sr <= '0;
          wdata_sr <= '0;
        end else if (chip_rise) begin
          if (advld_s) raddr_sr <= {raddr_sr[ROW_AW-2:0], rad_s[i]};
          if (dvld_s)  wdata_sr <= {wdata_sr[ROW_W-2:0], din_s[i]};
        end
      end

      // Memory array is intentionally not reset so contents survive RST
      always_ff @(posedge CLK) begin
        if (do_write) mem[waddr_sr] <= wdata_sr;
      end

      // Read shifter: load on RD entry, zero-filled shift while streaming
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)           rd_sr <= '0;
        else if (do_load)  rd_sr <= load_val;
        else if (do_shift) rd_sr <= {rd_sr[ROW_W-2:0], 1'b0};
      end

      assign rd_msb[i] = rd_sr[ROW_W-1];
    end
  endgenerate

  // Registered ROUT, forced low outside RD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                rout_r <= '0;
    else if (state == S_RD) rout_r <= rd_msb;
    else                    rout_r <= '0;
  end

  // Sticky protocol-violation flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          err_r <= 1'b0;
    else if (set_err) err_r <= 1'b1;
  end

  assign ROUT = rout_r;
  assign BUSY = (state != S_IDLE);
  assign ERR  = err_r;

endmodule

`default_nettype wire

// File: tb/tb_dram_cim_chip_emu.sv
// ============================================================================
// Module  : tb_dram_cim_chip_emu
// Brief   : Directed self-checking bench for dram_cim_chip_emu. Drives the
//           serial pin protocol with a chip clock of 8 CLK periods and keeps
//           a small memory model of committed rows.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_cim_chip_emu;

  localparam int NC = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CLK_chip = 1'b0;
  logic          ADDIN = 1'b0;
  logic          ADVLD = 1'b0;
  logic [NC-1:0] RAD = '0;
  logic [NC-1:0] DIN = '0;
  logic          DVLD = 1'b0;
  logic          WRIEN = 1'b0;
  logic          RDEN = 1'b0;
  logic [1:0]    LIMSEL = 2'b00;
  logic [NC-1:0] LIMIN = '0;
  logic [NC-1:0] ROUT;
  logic          BUSY;
  logic          ERR;

  dram_cim_chip_emu #(.NCORE(NC), .ROW_AW(6), .ROW_W(64)) dut (
    .CLK(CLK), .RST(RST), .CLK_chip(CLK_chip), .ADDIN(ADDIN), .ADVLD(ADVLD),
    .RAD(RAD), .DIN(DIN), .DVLD(DVLD), .WRIEN(WRIEN), .RDEN(RDEN),
    .LIMSEL(LIMSEL), .LIMIN(LIMIN), .ROUT(ROUT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] wd [NC];
  logic [63:0] mem_m [NC][64];
  logic        vld_m [NC][64];
  logic [5:0]  cur_wa = '0;
  logic [5:0]  cur_ra = '0;
  logic [NC-1:0] lim_xor = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One chip clock period: 4 CLK high, 4 CLK low; inputs move only at negedge CLK
  task automatic chip_tick();
    CLK_chip = 1'b1;
    repeat (4) @(negedge CLK);
    CLK_chip = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic shift_addr(input logic [7:0] wa, input logic [7:0] ra, input int nbits);
    ADVLD = 1'b1;
    for (int b = nbits - 1; b >= 0; b--) begin
      ADDIN = wa[b];
      RAD   = {NC{ra[b]}};
      chip_tick();
    end
    ADVLD = 1'b0;
    cur_wa = wa[5:0];
    cur_ra = ra[5:0];
  endtask

  task automatic shift_data();
    DVLD = 1'b1;
    for (int b = 63; b >= 0; b--) begin
      for (int i = 0; i < NC; i++) DIN[i] = wd[i][b];
      chip_tick();
    end
    DVLD = 1'b0;
  endtask

  task automatic write_row(input string tag);
    WRIEN = 1'b1;
    chip_tick();
    check({tag, " busy_wr"}, 64'(BUSY), 64'd1);
    WRIEN = 1'b0;
    chip_tick();
    check({tag, " busy_after_wr"}, 64'(BUSY), 64'd0);
    for (int i = 0; i < NC; i++) begin
      mem_m[i][cur_wa] = wd[i];
      vld_m[i][cur_wa] = 1'b1;
    end
  endtask

  task automatic read_check(input string tag);
    logic [63:0] got [NC];
    RDEN = 1'b1;
    chip_tick();
    check({tag, " busy_rd"}, 64'(BUSY), 64'd1);
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < NC; i++) got[i][63-k] = ROUT[i];
      chip_tick();
    end
    for (int i = 0; i < NC; i++)
      if (vld_m[i][cur_ra])
        check($sformatf("%s lane%0d", tag, i), got[i], mem_m[i][cur_ra] ^ {64{lim_xor[i]}});
    check({tag, " tail_zero"}, 64'(ROUT), 64'd0);
    RDEN = 1'b0;
    chip_tick();
    check({tag, " rout_idle"}, 64'(ROUT), 64'd0);
    check({tag, " busy_idle"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++)
      for (int r = 0; r < 64; r++) vld_m[i][r] = 1'b0;

    repeat (3) @(negedge CLK);
    check("reset ROUT", 64'(ROUT), 64'd0);
    check("reset BUSY", 64'(BUSY), 64'd0);
    check("reset ERR",  64'(ERR),  64'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Core 0 row 5 with the reference pattern, other lanes distinct
    for (int i = 0; i < NC; i++) wd[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    wd[0] = 64'hDEADBEEF_01234567;
    shift_addr(8'd5, 8'd5, 6);
    shift_data();
    write_row("row5");
    read_check("row5");

    // Row 63 on every core with distinct data
    for (int i = 0; i < NC; i++) wd[i] = {16{i[3:0]}} ^ 64'h0F1E_2D3C_4B5A_6978;
    shift_addr(8'd63, 8'd63, 6);
    shift_data();
    write_row("row63");
    read_check("row63");

    // 8 address bits A5: only the last 6 (6'h25) are kept
    for (int i = 0; i < NC; i++) wd[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 7 + 3);
    shift_addr(8'hA5, 8'hA5, 8);
    check("addr_trunc model", 64'(cur_wa), 64'h25);
    shift_data();
    write_row("row25");
    read_check("row25");

    // Simultaneous WRIEN/RDEN rise: error, no access
    for (int i = 0; i < NC; i++) wd[i] = ~64'(i);
    shift_data();
    WRIEN = 1'b1;
    RDEN  = 1'b1;
    chip_tick();
    check("dual ERR",  64'(ERR),  64'd1);
    check("dual BUSY", 64'(BUSY), 64'd0);
    check("dual ROUT", 64'(ROUT), 64'd0);
    WRIEN = 1'b0;
    RDEN  = 1'b0;
    chip_tick();
    read_check("after_dual");
    check("err sticky", 64'(ERR), 64'd1);

    // Reset in the middle of a read stream
    shift_addr(8'd63, 8'd63, 6);
    RDEN = 1'b1;
    repeat (10) chip_tick();
    check("midstream BUSY", 64'(BUSY), 64'd1);
    RST = 1'b1;
    #1;
    check("rst ROUT", 64'(ROUT), 64'd0);
    check("rst BUSY", 64'(BUSY), 64'd0);
    check("rst ERR",  64'(ERR),  64'd0);
    RDEN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    shift_addr(8'd63, 8'd63, 6);
    read_check("reread63");

`ifdef DRAM_EMU_LIM_EN
    // XOR with an all-ones operand on lane 0 over a zero row
    for (int i = 0; i < NC; i++) wd[i] = 64'h0;
    shift_addr(8'd0, 8'd0, 6);
    shift_data();
    write_row("row0");
    LIMSEL = 2'b01;
    LIMIN  = 16'h0001;
    lim_xor = 16'h0001;
    read_check("lim_xor");
    LIMSEL = 2'b00;
    LIMIN  = '0;
    lim_xor = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
